frame_scheduler: RTL and testbench

FRAME_SCHEDULER -- requirements
Module: frame_scheduler

---
 rtl/frame_scheduler_pkg.sv | 28 ++
 rtl/frame_scheduler_if.sv | 28 ++
 rtl/frame_scheduler_screen_clearer.sv | 63 ++++++
 rtl/frame_scheduler.sv | 132 +++++++++++++
 tb/tb_frame_scheduler.sv | 298 +++++++++++++++++++++++++++++
 5 files changed

// File: rtl/frame_scheduler_pkg.sv
// Shared types and constants for the frame scheduler and its raster clearer.
package frame_scheduler_pkg;

  localparam int unsigned COORD_W = 10;
  localparam int unsigned COLOR_W = 3;
  localparam int unsigned OVR_W   = 8;

  typedef logic [COORD_W-1:0] coord_t;
  typedef logic [COLOR_W-1:0] color_t;

  localparam color_t BG_COLOR_DEFAULT = 3'b000;

  typedef enum logic [1:0] {
    ST_IDLE     = 2'd0,
    ST_SNAPSHOT = 2'd1,
    ST_CLEAR    = 2'd2,
    ST_DRAW     = 2'd3
  } state_t;

  // One pixel-port beat towards the VGA adapter
  typedef struct packed {
    coord_t x;
    coord_t y;
    color_t color;
    logic   plot;
  } pixel_t;

endpackage : frame_scheduler_pkg

// File: rtl/frame_scheduler_if.sv
// Draw-controller handshake plus the pixel port of the VGA adapter.
interface frame_scheduler_if;
  import frame_scheduler_pkg::*;

  coord_t dc_x;
  coord_t dc_y;
  color_t dc_color;
  logic   dc_plot;
  logic   dc_done;
  logic   dc_start;

  coord_t x;
  coord_t y;
  color_t color;
  logic   plot;

  // Scheduler side
  modport slave (
    input  dc_x, dc_y, dc_color, dc_plot, dc_done,
    output dc_start, x, y, color, plot
  );

  // Draw controller / adapter side
  modport master (
    output dc_x, dc_y, dc_color, dc_plot, dc_done,
    input  dc_start, x, y, color, plot
  );
endinterface : frame_scheduler_if

// File: rtl/frame_scheduler_screen_clearer.sv
// Raster walker: after a start pulse emits one pixel per cycle over the whole screen.
module screen_clearer
  import frame_scheduler_pkg::*;
#(
  parameter int unsigned SCREEN_W = 160,
  parameter int unsigned SCREEN_H = 120
) (
  input  logic   clk,
  input  logic   reset_n,
  input  logic   start,
  output coord_t x,
  output coord_t y,
  output logic   plot,
  output logic   last
);

  coord_t cx_q, cx_d;
  coord_t cy_q, cy_d;
  logic   run_q, run_d;

  assign x    = cx_q;
  assign y    = cy_q;
  assign plot = run_q;
  assign last = run_q && (cx_q == COORD_W'(SCREEN_W - 1))
                      && (cy_q == COORD_W'(SCREEN_H - 1));

  // Raster advance: x inner, y outer, wrap to origin after the final pixel
  always_comb begin
    cx_d  = cx_q;
    cy_d  = cy_q;
    run_d = run_q;
    if (start) begin
      run_d = 1'b1;
      cx_d  = '0;
      cy_d  = '0;
    end else if (run_q) begin
      if (last) begin
        run_d = 1'b0;
        cx_d  = '0;
        cy_d  = '0;
      end else if (cx_q == COORD_W'(SCREEN_W - 1)) begin
        cx_d = '0;
        cy_d = cy_q + COORD_W'(1);
      end else begin
        cx_d = cx_q + COORD_W'(1);
      end
    end
  end

  // Counter registers
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      cx_q  <= '0;
      cy_q  <= '0;
      run_q <= 1'b0;
    end else begin
      cx_q  <= cx_d;
      cy_q  <= cy_d;
      run_q <= run_d;
    end
  end

endmodule : screen_clearer

// File: rtl/frame_scheduler.sv
// Sequences each frame: snapshot game state, clear the framebuffer, hand the pixel port to the draw controller.
module frame_scheduler
  import frame_scheduler_pkg::*;
#(
  parameter int unsigned SCREEN_W     = 160,
  parameter int unsigned SCREEN_H     = 120,
  parameter color_t      BG_COLOR     = BG_COLOR_DEFAULT,
  parameter int unsigned DRAW_TIMEOUT = 65535
) (
  input  logic               clk,
  input  logic               reset_n,
  input  logic               frame_tick,
  frame_scheduler_if.slave   bus,
  output logic               snapshot_en,
  output logic               busy,
  output logic [OVR_W-1:0]   overrun_cnt,
  output logic               timeout_flag
);

  localparam int unsigned CNT_W = $clog2(DRAW_TIMEOUT + 1);

  state_t             state_q, state_d;
  logic [CNT_W-1:0]   draw_cnt_q, draw_cnt_d;
  logic [OVR_W-1:0]   overrun_q, overrun_d;
  logic               timeout_flag_q, timeout_flag_d;
  logic               snapshot_en_q, snapshot_en_d;
  logic               dc_start_q, dc_start_d;

  logic               clr_start;
  coord_t             clr_x;
  coord_t             clr_y;
  logic               clr_plot;
  logic               clr_last;
  logic               timeout_hit;
  pixel_t             pix;

  screen_clearer #(
    .SCREEN_W (SCREEN_W),
    .SCREEN_H (SCREEN_H)
  ) u_clearer (
    .clk     (clk),
    .reset_n (reset_n),
    .start   (clr_start),
    .x       (clr_x),
    .y       (clr_y),
    .plot    (clr_plot),
    .last    (clr_last)
  );

  // DRAW gives up once it has spent DRAW_TIMEOUT cycles without dc_done
  assign timeout_hit = (state_q == ST_DRAW) && (draw_cnt_q == CNT_W'(DRAW_TIMEOUT - 1));

  // State register
  always_ff @(posedge clk) begin
    if (!reset_n) state_q <= ST_IDLE;
    else          state_q <= state_d;
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE:     if (frame_tick) state_d = ST_SNAPSHOT;
      ST_SNAPSHOT: state_d = ST_CLEAR;
      ST_CLEAR:    if (clr_last) state_d = ST_DRAW;
      ST_DRAW:     if (bus.dc_done || timeout_hit) state_d = ST_IDLE;
      default:     state_d = ST_IDLE;
    endcase
  end

  // Output decode: pixel-port mux and next values of the one-shot pulses
  always_comb begin
    pix           = '{x: '0, y: '0, color: BG_COLOR, plot: 1'b0};
    clr_start     = 1'b0;
    dc_start_d    = 1'b0;
    snapshot_en_d = (state_q == ST_IDLE) && frame_tick;
    case (state_q)
      ST_SNAPSHOT: clr_start = 1'b1;
      ST_CLEAR: begin
        pix        = '{x: clr_x, y: clr_y, color: BG_COLOR, plot: clr_plot};
        dc_start_d = clr_last;
      end
      ST_DRAW:
        pix = '{x: bus.dc_x, y: bus.dc_y, color: bus.dc_color, plot: bus.dc_plot};
      default: ;
    endcase
  end

  // DRAW cycle counter, overrun counter and sticky timeout flag
  always_comb begin
    draw_cnt_d     = '0;
    overrun_d      = overrun_q;
    timeout_flag_d = timeout_flag_q;
    if (state_q == ST_DRAW && state_d == ST_DRAW) begin
      draw_cnt_d = draw_cnt_q + CNT_W'(1);
    end
    if (frame_tick && state_q != ST_IDLE && overrun_q != {OVR_W{1'b1}}) begin
      overrun_d = overrun_q + OVR_W'(1);
    end
    if (timeout_hit && !bus.dc_done) begin
      timeout_flag_d = 1'b1;
    end
  end

  // Datapath and pulse registers
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      draw_cnt_q     <= '0;
      overrun_q      <= '0;
      timeout_flag_q <= 1'b0;
      snapshot_en_q  <= 1'b0;
      dc_start_q     <= 1'b0;
    end else begin
      draw_cnt_q     <= draw_cnt_d;
      overrun_q      <= overrun_d;
      timeout_flag_q <= timeout_flag_d;
      snapshot_en_q  <= snapshot_en_d;
      dc_start_q     <= dc_start_d;
    end
  end

  assign bus.x        = pix.x;
  assign bus.y        = pix.y;
  assign bus.color    = pix.color;
  assign bus.plot     = pix.plot;
  assign bus.dc_start = dc_start_q;
  assign snapshot_en  = snapshot_en_q;
  assign busy         = (state_q != ST_IDLE);
  assign overrun_cnt  = overrun_q;
  assign timeout_flag = timeout_flag_q;

endmodule : frame_scheduler

// File: tb/tb_frame_scheduler.sv
// Scoreboard bench for frame_scheduler (4x2 screen, 20-cycle draw timeout).
module tb_frame_scheduler;
  import frame_scheduler_pkg::*;

  typedef enum int {S_X, S_Y, S_COLOR, S_PLOT, S_BUSY, S_DCSTART, S_SNAP, S_OVR, S_TOF} sig_e;

  typedef struct {
    int    cyc;
    string name;
    sig_e  sig;
    int    val;
  } exp_t;

  logic       clk = 1'b0;
  logic       reset_n;
  logic       frame_tick;
  logic       snapshot_en;
  logic       busy;
  logic [7:0] overrun_cnt;
  logic       timeout_flag;

  int   cyc = 0;
  int   checks = 0;
  int   errors = 0;
  exp_t sb[$];

  frame_scheduler_if bus ();

  frame_scheduler #(
    .SCREEN_W     (4),
    .SCREEN_H     (2),
    .BG_COLOR     (3'b000),
    .DRAW_TIMEOUT (20)
  ) dut (
    .clk          (clk),
    .reset_n      (reset_n),
    .frame_tick   (frame_tick),
    .bus          (bus),
    .snapshot_en  (snapshot_en),
    .busy         (busy),
    .overrun_cnt  (overrun_cnt),
    .timeout_flag (timeout_flag)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  function automatic logic [31:0] act_of(sig_e s);
    case (s)
      S_X:       return 32'(bus.x);
      S_Y:       return 32'(bus.y);
      S_COLOR:   return 32'(bus.color);
      S_PLOT:    return 32'(bus.plot);
      S_BUSY:    return 32'(busy);
      S_DCSTART: return 32'(bus.dc_start);
      S_SNAP:    return 32'(snapshot_en);
      S_OVR:     return 32'(overrun_cnt);
      default:   return 32'(timeout_flag);
    endcase
  endfunction

  // Monitor: pop every expectation due this cycle and compare mid-cycle
  always @(negedge clk) begin
    while (sb.size() > 0 && sb[0].cyc <= cyc) begin
      exp_t        e;
      logic [31:0] a;
      e = sb.pop_front();
      a = act_of(e.sig);
      checks++;
      if (e.cyc != cyc || a !== 32'(e.val)) begin
        errors++;
        $display("FAIL %s cyc %0d (due %0d): got %0d expected %0d", e.name, cyc, e.cyc, a, e.val);
      end
    end
  end

  task automatic expect_at(input int c, input string nm, input sig_e s, input int v);
    exp_t e;
    e.cyc = c; e.name = nm; e.sig = s; e.val = v;
    sb.push_back(e);
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic advance(input int n);
    for (int i = 0; i < n; i++) step();
  endtask

  // Issue frame_tick in the current cycle and advance to the given offset from it
  task automatic frame_to(input int off);
    frame_tick = 1'b1;
    step();
    frame_tick = 1'b0;
    advance(off - 1);
  endtask

  initial begin
    repeat (5000) @(posedge clk);
    $display("FAIL watchdog: bench stalled at cycle %0d", cyc);
    $fatal(1, "watchdog");
  end

  initial begin
    int b;
    reset_n      = 1'b0;
    frame_tick   = 1'b1;
    bus.dc_x     = '0;
    bus.dc_y     = '0;
    bus.dc_color = '0;
    bus.dc_plot  = 1'b0;
    bus.dc_done  = 1'b0;

    // Reset with a coincident frame_tick
    step();
    step();
    expect_at(cyc, "rst_busy", S_BUSY, 0);
    expect_at(cyc, "rst_plot", S_PLOT, 0);
    expect_at(cyc, "rst_ovr", S_OVR, 0);
    expect_at(cyc, "rst_tof", S_TOF, 0);
    expect_at(cyc, "rst_snap", S_SNAP, 0);
    expect_at(cyc, "rst_dcstart", S_DCSTART, 0);
    reset_n    = 1'b1;
    frame_tick = 1'b0;
    step();
    expect_at(cyc, "rst_tick_ignored", S_BUSY, 0);
    expect_at(cyc, "rst_tick_nosnap", S_SNAP, 0);

    // Basic frame: snapshot, 8-pixel clear, draw pass-through, done
    b = cyc;
    expect_at(b, "idle_busy", S_BUSY, 0);
    frame_tick = 1'b1;
    step();
    frame_tick   = 1'b0;
    bus.dc_plot  = 1'b1;
    bus.dc_x     = 10'd9;
    bus.dc_color = 3'b111;
    expect_at(cyc, "snap_en", S_SNAP, 1);
    expect_at(cyc, "snap_busy", S_BUSY, 1);
    expect_at(cyc, "snap_plot", S_PLOT, 0);
    expect_at(cyc, "snap_x", S_X, 0);
    expect_at(cyc, "snap_color", S_COLOR, 0);
    for (int i = 0; i < 8; i++) begin
      step();
      expect_at(cyc, "clr_plot", S_PLOT, 1);
      expect_at(cyc, "clr_x", S_X, i % 4);
      expect_at(cyc, "clr_y", S_Y, i / 4);
      expect_at(cyc, "clr_color", S_COLOR, 0);
      if (i == 0) expect_at(cyc, "snap_one_cycle", S_SNAP, 0);
      if (i == 7) expect_at(cyc, "clr_no_dcstart", S_DCSTART, 0);
    end
    step();
    bus.dc_x     = 10'd5;
    bus.dc_y     = 10'd7;
    bus.dc_color = 3'b101;
    bus.dc_plot  = 1'b1;
    expect_at(cyc, "draw_dcstart", S_DCSTART, 1);
    expect_at(cyc, "draw_x", S_X, 5);
    expect_at(cyc, "draw_y", S_Y, 7);
    expect_at(cyc, "draw_color", S_COLOR, 5);
    expect_at(cyc, "draw_plot", S_PLOT, 1);
    step();
    bus.dc_plot = 1'b0;
    bus.dc_done = 1'b1;
    expect_at(cyc, "dcstart_pulse", S_DCSTART, 0);
    expect_at(cyc, "draw_plot_off", S_PLOT, 0);
    expect_at(cyc, "draw_busy", S_BUSY, 1);
    step();
    bus.dc_done = 1'b0;
    expect_at(cyc, "done_idle", S_BUSY, 0);
    expect_at(cyc, "done_plot", S_PLOT, 0);
    expect_at(cyc, "done_ovr", S_OVR, 0);

    // Overruns during CLEAR, plus a tick in the cycle DRAW ends
    b = cyc;
    frame_to(3);
    frame_tick = 1'b1;
    advance(3);
    frame_tick = 1'b0;
    expect_at(cyc, "ovr3", S_OVR, 3);
    expect_at(cyc, "ovr_no_restart_x", S_X, 0);
    expect_at(cyc, "ovr_no_restart_y", S_Y, 1);
    advance(b + 10 - cyc);
    expect_at(cyc, "ovr_dcstart", S_DCSTART, 1);
    bus.dc_done = 1'b1;
    frame_tick  = 1'b1;
    step();
    bus.dc_done = 1'b0;
    frame_tick  = 1'b0;
    expect_at(cyc, "ovr_exit_tick", S_OVR, 4);
    expect_at(cyc, "ovr_exit_idle", S_BUSY, 0);
    step();
    expect_at(cyc, "ovr_exit_no_frame", S_BUSY, 0);

    // dc_done on the last allowed DRAW cycle beats the timeout
    b = cyc;
    frame_to(29);
    expect_at(cyc, "tie_busy", S_BUSY, 1);
    bus.dc_done = 1'b1;
    step();
    bus.dc_done = 1'b0;
    expect_at(cyc, "tie_idle", S_BUSY, 0);
    expect_at(cyc, "tie_tof", S_TOF, 0);

    // No dc_done: timeout after 20 DRAW cycles, flag sticky into next frame
    b = cyc;
    frame_to(29);
    expect_at(cyc, "to_busy_last", S_BUSY, 1);
    expect_at(cyc, "to_tof_pre", S_TOF, 0);
    step();
    expect_at(cyc, "to_idle", S_BUSY, 0);
    expect_at(cyc, "to_tof", S_TOF, 1);
    expect_at(cyc, "to_plot", S_PLOT, 0);
    frame_to(10);
    expect_at(cyc, "to_next_dcstart", S_DCSTART, 1);
    expect_at(cyc, "to_sticky_draw", S_TOF, 1);
    bus.dc_done = 1'b1;
    step();
    bus.dc_done = 1'b0;
    expect_at(cyc, "to_next_idle", S_BUSY, 0);
    expect_at(cyc, "to_sticky_idle", S_TOF, 1);

    // Continuous ticks across back-to-back frames saturate the overrun count
    frame_tick  = 1'b1;
    bus.dc_done = 1'b1;
    advance(300);
    expect_at(cyc, "sat_ovr", S_OVR, 255);
    frame_tick = 1'b0;
    advance(12);
    bus.dc_done = 1'b0;
    expect_at(cyc, "sat_ovr_hold", S_OVR, 255);
    expect_at(cyc, "sat_idle", S_BUSY, 0);
    expect_at(cyc, "sat_tof", S_TOF, 1);

    // Reset while clearing pixel (2,0), then a clean restart
    b = cyc;
    frame_to(4);
    expect_at(cyc, "mid_x", S_X, 2);
    expect_at(cyc, "mid_plot", S_PLOT, 1);
    reset_n = 1'b0;
    step();
    expect_at(cyc, "mrst_plot", S_PLOT, 0);
    expect_at(cyc, "mrst_busy", S_BUSY, 0);
    expect_at(cyc, "mrst_x", S_X, 0);
    expect_at(cyc, "mrst_ovr", S_OVR, 0);
    expect_at(cyc, "mrst_tof", S_TOF, 0);
    expect_at(cyc, "mrst_snap", S_SNAP, 0);
    expect_at(cyc, "mrst_dcstart", S_DCSTART, 0);
    reset_n = 1'b1;
    step();
    expect_at(cyc, "mrst_stay_idle", S_BUSY, 0);
    expect_at(cyc, "mrst_no_plot", S_PLOT, 0);
    frame_to(1);
    expect_at(cyc, "re_snap", S_SNAP, 1);
    step();
    expect_at(cyc, "re_x0", S_X, 0);
    expect_at(cyc, "re_y0", S_Y, 0);
    expect_at(cyc, "re_plot", S_PLOT, 1);
    step();
    expect_at(cyc, "re_x1", S_X, 1);
    advance(7);
    expect_at(cyc, "re_dcstart", S_DCSTART, 1);
    bus.dc_done = 1'b1;
    step();
    bus.dc_done = 1'b0;
    expect_at(cyc, "re_idle", S_BUSY, 0);

    // dc_done and dc_plot while IDLE are ignored
    bus.dc_done = 1'b1;
    bus.dc_plot = 1'b1;
    bus.dc_x    = 10'd3;
    expect_at(cyc, "idle_plot_block", S_PLOT, 0);
    expect_at(cyc, "idle_x_block", S_X, 0);
    step();
    expect_at(cyc, "idle_done_busy", S_BUSY, 0);
    expect_at(cyc, "idle_done_plot", S_PLOT, 0);
    step();
    bus.dc_done = 1'b0;
    bus.dc_plot = 1'b0;
    expect_at(cyc, "idle_done_snap", S_SNAP, 0);
    expect_at(cyc, "idle_done_dcstart", S_DCSTART, 0);

    step();
    @(negedge clk);
    #1;
    if (sb.size() != 0) begin
      checks++;
      errors++;
      $display("FAIL scoreboard_drain: %0d expectations left, expected 0", sb.size());
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule : tb_frame_scheduler
